clue_turn_controller: RTL and testbench
=======================================

// Module: clue_turn_controller
// PURPOSE
// Game-turn sequencer upstream of the VGA display controller. Owns the 4 token positions,
// the active player, the dice roll and the prompt/dice overlay flags. It consumes the
// debounced buttons and the frame tick, and drives the position and overlay inputs of the
// display stage. It replaces per-switch token selection with strict round-robin turns.
// PARAMETERS
// STEP_PX      20   pixels moved per step (one board tile)
// ROLL_FRAMES  30   frame ticks of dice animation before the value latches
// X_LO/X_HI    100/520  inclusive token-centre x bounds
// Y_LO/Y_HI    30/450   inclusive token-centre y bounds
// PORTS
// clk          in   1   100 MHz system clock (sole clock)
// reset        in   1   synchronous, active-high
// screen_end   in   1   frame tick from timing generator, any width; rising edge used
// BTNU/BTND/BTNL/BTNR/BTNC in 1 each  debounced buttons, level; rising edge used
// tok_x        out  40  {t3,t2,t1,t0} token x, 10b each
// tok_y        out  40  {t3,t2,t1,t0} token y, 10b each
// cur_player   out  2   player whose turn it is
// dice_value   out  3   1..6 shown on dice overlay
// steps_left   out  3   remaining steps in MOVE
// show_prompt  out  1   "roll dice" overlay enable
// show_dice    out  1   dice overlay enable
// turn_done    out  1   1-cycle pulse on entering NEXT
// BEHAVIOUR
// - Reset: tokens (400,30),(280,440),(520,150),(120,340); cur_player=0; dice_value=1;
//   steps_left=0; show_prompt=1; show_dice=0; turn_done=0; state=PROMPT; edge regs cleared.
// - All inputs are registered once, and edges are detected on the registered copy. An edge is
//   acted on 2 clk after the input pin rises. All outputs are registered.
// - Dice counter: free-running every clk, 1..6, wraps 6->1. It never holds 0 or 7.
// - PROMPT: show_prompt=1, show_dice=0. BTNC edge -> ROLL, frame counter cleared.
// - ROLL: show_dice=1, show_prompt=0. Each screen_end edge copies the dice counter to
//   dice_value and increments the frame counter. On the ROLL_FRAMES-th edge, steps_left is
//   loaded with the dice_value written on that same edge, and the state goes to MOVE.
//   Buttons are ignored in ROLL.
// - MOVE: show_dice=1. One direction edge = one step request, with priority D>U>L>R when
//   several edges occur in the same cycle; the others are dropped.
//   - If the new coordinate lies within [LO,HI], the token moves by STEP_PX and steps_left
//     decrements.
//   - If the new coordinate lies outside [LO,HI], the position and steps_left are unchanged
//     (a rejected move costs nothing).
//   - steps_left reaching 0, or a BTNC edge (ends the turn early), -> NEXT.
//   - BTNC and a direction edge in the same cycle: BTNC wins, no move.
// - NEXT: one cycle. turn_done=1; cur_player+1 mod 4 (3->0); show_dice=0; -> PROMPT.
// - Tokens may overlap; no collision check.
// - Arithmetic: bounds checks are done in 11-bit unsigned on x-STEP_PX and y-STEP_PX, so an
//   underflow appears as a large value and is rejected.
// - Reset mid-operation: an immediate full return to the reset state, including positions.
// STRUCTURE
// - Shared include clue_defs.vh: state encodings (PROMPT, ROLL, MOVE, NEXT), board bounds,
//   start coordinates, STEP_PX. The display controller uses the same include for bounds.
// - One sub-module, dice_roller: free-running 1..6 counter, plus the frame-tick animation
//   counter with a done pulse.
// - Top level: edge detectors, FSM, and the position register file with its bounds check.
// TESTING
// 1 Reset -> tok_x={120,520,280,400}, tok_y={340,150,440,30}, show_prompt=1, cur_player=0.
// 2 BTNC, then 30 screen_end pulses -> show_dice=1, state MOVE, steps_left=dice_value in 1..6;
//   dice_value never 0 or 7 over 1000 rolls.
// 3 Force dice=3, player 0: BTNR x3 -> tok0 x 400->460, steps 0, turn_done pulse,
//   cur_player=1.
// 4 Player 0 at y=30: BTNU -> y stays 30, steps_left unchanged; then BTND -> y=50.
// 5 MOVE, steps_left=4: BTNC -> NEXT at once, positions unchanged beyond prior steps;
//   player 3 wraps to 0.
// 6 Reset asserted mid-MOVE after 2 steps -> all reset values restored next cycle.

Source files
------------

// File: rtl/clue_turn_controller_pkg.sv
// Shared definitions for the clue turn sequencer: FSM states, board bounds,
// start positions and step size. The display stage reuses the bounds.
package clue_turn_controller_pkg;

  typedef enum logic [1:0] {
    S_PROMPT = 2'd0,
    S_ROLL   = 2'd1,
    S_MOVE   = 2'd2,
    S_NEXT   = 2'd3
  } state_t;

  localparam int DEF_STEP_PX     = 20;
  localparam int DEF_ROLL_FRAMES = 30;
  localparam int DEF_X_LO        = 100;
  localparam int DEF_X_HI        = 520;
  localparam int DEF_Y_LO        = 30;
  localparam int DEF_Y_HI        = 450;

  // Packed {t3,t2,t1,t0}, 10 bits per token
  localparam logic [39:0] START_X = {10'd120, 10'd520, 10'd280, 10'd400};
  localparam logic [39:0] START_Y = {10'd340, 10'd150, 10'd440, 10'd30};

  function automatic logic in_range(input logic [10:0] v,
                                    input logic [10:0] lo,
                                    input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/clue_turn_controller_dice_roller.sv
// Free-running 1..6 dice counter plus the frame-tick animation counter that
// signals when the roll animation has run its full length.
module dice_roller #(
  parameter int ROLL_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_tick,
  output logic [2:0] o_dice,
  output logic       o_done
);
  localparam int FW = $clog2(ROLL_FRAMES) + 1;

  logic [2:0]    r_dice;
  logic [FW-1:0] r_frames;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dice   <= 3'd1;
      r_frames <= '0;
    end else begin
      r_dice <= (r_dice == 3'd6) ? 3'd1 : r_dice + 3'd1;
      if (i_clear)     r_frames <= '0;
      else if (i_tick) r_frames <= r_frames + 1'b1;
    end
  end

  assign o_dice = r_dice;
  // Fires on the ROLL_FRAMES-th tick itself so the caller can latch that roll
  assign o_done = i_tick && (r_frames == FW'(ROLL_FRAMES - 1));

endmodule

// File: rtl/clue_turn_controller.sv
// Round-robin turn sequencer: button/frame edge detection, PROMPT/ROLL/MOVE/NEXT
// FSM and the four-token position file with board bounds checking.
module clue_turn_controller
  import clue_turn_controller_pkg::*;
#(
  parameter int STEP_PX     = DEF_STEP_PX,
  parameter int ROLL_FRAMES = DEF_ROLL_FRAMES,
  parameter int X_LO        = DEF_X_LO,
  parameter int X_HI        = DEF_X_HI,
  parameter int Y_LO        = DEF_Y_LO,
  parameter int Y_HI        = DEF_Y_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        screen_end,
  input  logic        BTNU,
  input  logic        BTND,
  input  logic        BTNL,
  input  logic        BTNR,
  input  logic        BTNC,
  output logic [39:0] tok_x,
  output logic [39:0] tok_y,
  output logic [1:0]  cur_player,
  output logic [2:0]  dice_value,
  output logic [2:0]  steps_left,
  output logic        show_prompt,
  output logic        show_dice,
  output logic        turn_done
);
  // Bit map of the input/edge vectors: 5 screen_end, 4 C, 3 U, 2 D, 1 L, 0 R
  logic [5:0] r_in, r_in_d;
  logic [5:0] w_rise;

  state_t          r_state;
  logic [3:0][9:0] r_x, r_y;
  logic [1:0]      r_player;
  logic [2:0]      r_dice_val, r_steps;
  logic            r_prompt, r_show_dice, r_turn_done;

  logic [2:0]  w_dice;
  logic        w_done, w_tick, w_clear;
  logic [9:0]  w_cx, w_cy;
  logic [10:0] w_nx, w_ny;
  logic        w_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in   <= '0;
      r_in_d <= '0;
    end else begin
      r_in   <= {screen_end, BTNC, BTNU, BTND, BTNL, BTNR};
      r_in_d <= r_in;
    end
  end

  assign w_rise  = r_in & ~r_in_d;
  assign w_tick  = w_rise[5] && (r_state == S_ROLL);
  assign w_clear = (r_state == S_PROMPT);

  dice_roller #(.ROLL_FRAMES(ROLL_FRAMES)) u_dice (
    .clk    (clk),
    .reset  (reset),
    .i_clear(w_clear),
    .i_tick (w_tick),
    .o_dice (w_dice),
    .o_done (w_done)
  );

  // One step request per cycle, D>U>L>R; 11-bit math makes underflow out of range
  always_comb begin
    w_cx = r_x[r_player];
    w_cy = r_y[r_player];
    w_nx = {1'b0, w_cx};
    w_ny = {1'b0, w_cy};
    if (w_rise[2])      w_ny = {1'b0, w_cy} + 11'(STEP_PX);
    else if (w_rise[3]) w_ny = {1'b0, w_cy} - 11'(STEP_PX);
    else if (w_rise[1]) w_nx = {1'b0, w_cx} - 11'(STEP_PX);
    else if (w_rise[0]) w_nx = {1'b0, w_cx} + 11'(STEP_PX);
    w_ok = (|w_rise[3:0])
        && in_range(w_nx, 11'(X_LO), 11'(X_HI))
        && in_range(w_ny, 11'(Y_LO), 11'(Y_HI));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_PROMPT;
      r_x         <= START_X;
      r_y         <= START_Y;
      r_player    <= 2'd0;
      r_dice_val  <= 3'd1;
      r_steps     <= 3'd0;
      r_prompt    <= 1'b1;
      r_show_dice <= 1'b0;
      r_turn_done <= 1'b0;
    end else begin
      r_turn_done <= 1'b0;
      case (r_state)
        S_PROMPT: begin
          if (w_rise[4]) begin
            r_state     <= S_ROLL;
            r_prompt    <= 1'b0;
            r_show_dice <= 1'b1;
          end
        end
        S_ROLL: begin
          if (w_tick) begin
            r_dice_val <= w_dice;
            if (w_done) begin
              r_steps <= w_dice;
              r_state <= S_MOVE;
            end
          end
        end
        S_MOVE: begin
          if (w_rise[4]) begin
            r_state     <= S_NEXT;
            r_turn_done <= 1'b1;
            r_show_dice <= 1'b0;
          end else if (w_ok) begin
            r_x[r_player] <= w_nx[9:0];
            r_y[r_player] <= w_ny[9:0];
            r_steps       <= r_steps - 3'd1;
            if (r_steps == 3'd1) begin
              r_state     <= S_NEXT;
              r_turn_done <= 1'b1;
              r_show_dice <= 1'b0;
            end
          end
        end
        S_NEXT: begin
          r_player <= r_player + 2'd1;
          r_prompt <= 1'b1;
          r_state  <= S_PROMPT;
        end
        default: r_state <= S_PROMPT;
      endcase
    end
  end

  assign tok_x       = r_x;
  assign tok_y       = r_y;
  assign cur_player  = r_player;
  assign dice_value  = r_dice_val;
  assign steps_left  = r_steps;
  assign show_prompt = r_prompt;
  assign show_dice   = r_show_dice;
  assign turn_done   = r_turn_done;

endmodule

// File: tb/tb_clue_turn_controller.sv
// Scoreboard bench for clue_turn_controller: directed turns push expected
// snapshots with a due cycle; a monitor pops and compares them.
module tb_clue_turn_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic screen_end = 1'b0;
  logic BTNU = 1'b0, BTND = 1'b0, BTNL = 1'b0, BTNR = 1'b0, BTNC = 1'b0;
  logic [39:0] tok_x, tok_y;
  logic [1:0]  cur_player;
  logic [2:0]  dice_value, steps_left;
  logic        show_prompt, show_dice, turn_done;

  clue_turn_controller dut (
    .clk(clk), .reset(reset), .screen_end(screen_end),
    .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR), .BTNC(BTNC),
    .tok_x(tok_x), .tok_y(tok_y), .cur_player(cur_player),
    .dice_value(dice_value), .steps_left(steps_left),
    .show_prompt(show_prompt), .show_dice(show_dice), .turn_done(turn_done)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] BC = 5'b10000, BU = 5'b01000, BD = 5'b00100,
                         BL = 5'b00010, BR = 5'b00001;

  typedef struct {
    int          due;
    logic [39:0] x, y;
    logic [1:0]  pl;
    logic [2:0]  dv, st;
    logic        pr, sd, td;
  } exp_t;

  exp_t q[$];
  exp_t mon_s;
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   m_dice = 1;

  int   e_x[4], e_y[4];
  int   e_pl, e_dv, e_st, e_pr, e_sd;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference dice phase: 1..6 wrap, restarting at 1 out of reset
  always @(posedge clk) m_dice <= reset ? 1 : ((m_dice == 6) ? 1 : m_dice + 1);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) chk("dice_range", 64'(dice_value >= 3'd1 && dice_value <= 3'd6), 64'd1);
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_s = q.pop_front();
      if (mon_s.due < cyc) begin
        chk("missed_due", 64'(cyc), 64'(mon_s.due));
      end else begin
        chk("tok_x",       64'(tok_x),       64'(mon_s.x));
        chk("tok_y",       64'(tok_y),       64'(mon_s.y));
        chk("cur_player",  64'(cur_player),  64'(mon_s.pl));
        chk("dice_value",  64'(dice_value),  64'(mon_s.dv));
        chk("steps_left",  64'(steps_left),  64'(mon_s.st));
        chk("show_prompt", 64'(show_prompt), 64'(mon_s.pr));
        chk("show_dice",   64'(show_dice),   64'(mon_s.sd));
        chk("turn_done",   64'(turn_done),   64'(mon_s.td));
      end
    end
  end

  task automatic push(input int due, input logic td);
    exp_t s;
    s.due = due;
    for (int i = 0; i < 4; i++) begin
      s.x[i*10 +: 10] = 10'(e_x[i]);
      s.y[i*10 +: 10] = 10'(e_y[i]);
    end
    s.pl = 2'(e_pl); s.dv = 3'(e_dv); s.st = 3'(e_st);
    s.pr = e_pr[0];  s.sd = e_sd[0];  s.td = td;
    q.push_back(s);
  endtask

  task automatic set_reset_exp();
    e_x = '{400, 280, 520, 120};
    e_y = '{30, 440, 150, 340};
    e_pl = 0; e_dv = 1; e_st = 0; e_pr = 1; e_sd = 0;
  endtask

  task automatic drive(input logic [4:0] b);
    {BTNC, BTNU, BTND, BTNL, BTNR} = b;
  endtask

  // Action is visible after the second rising edge following the pin rise
  task automatic mv(input logic [4:0] b, input int nx, input int ny,
                    input int nst, input logic done);
    e_x[e_pl] = nx; e_y[e_pl] = ny; e_st = nst;
    if (done) e_sd = 0;
    push(cyc + 2, done);
    if (done) begin
      e_pl = (e_pl + 1) % 4; e_pr = 1;
      push(cyc + 3, 1'b0);
    end
    drive(b);
    @(negedge clk); drive(5'b0);
    @(negedge clk); @(negedge clk);
  endtask

  task automatic roll(input int target);
    int prev;
    prev = (target == 1) ? 6 : target - 1;
    e_pr = 0; e_sd = 1;
    push(cyc + 2, 1'b0);
    drive(BC);
    @(negedge clk); drive(5'b0);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 29; i++) begin
      screen_end = 1'b1;
      if (i == 10) drive(BD | BC);   // ignored while rolling
      @(negedge clk);
      screen_end = 1'b0; drive(5'b0);
      @(negedge clk);
    end
    // Counter value used two edges later is the successor of the current one
    while (m_dice != prev) @(negedge clk);
    e_dv = target; e_st = target;
    push(cyc + 2, 1'b0);
    screen_end = 1'b1;
    @(negedge clk); screen_end = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_reset_exp();
    @(negedge clk); @(negedge clk);
    push(cyc + 1, 1'b0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // P0: dice 3, three steps right ends the turn
    roll(3);
    mv(BR, 420, 30, 2, 1'b0);
    mv(BR, 440, 30, 1, 1'b0);
    mv(BR, 460, 30, 0, 1'b1);

    // P1: y=440 down is out of board; up then early end
    roll(4);
    mv(BD, 280, 440, 4, 1'b0);
    mv(BU, 280, 420, 3, 1'b0);
    mv(BC, 280, 420, 3, 1'b1);

    // P2: x=520 right rejected, early end with 4 left
    roll(4);
    mv(BR, 520, 150, 4, 1'b0);
    mv(BC, 520, 150, 4, 1'b1);

    // P3: left onto x=100 boundary, then C with L same cycle; player wraps
    roll(2);
    mv(BL, 100, 340, 1, 1'b0);
    mv(BC | BL, 100, 340, 1, 1'b1);

    // P0 at y=30: up rejected, down accepted, D wins priority
    roll(5);
    mv(BU, 460, 30, 5, 1'b0);
    mv(BD, 460, 50, 4, 1'b0);
    mv(BD | BU | BL | BR, 460, 70, 3, 1'b0);
    mv(BL, 440, 70, 2, 1'b0);

    // Reset mid-MOVE restores everything on the next edge
    set_reset_exp();
    push(cyc + 1, 1'b0);
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk); @(negedge clk);

    roll(6);
    mv(BR, 420, 30, 5, 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_drain", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
